cache_set_assoc: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement and an explicit miss state machine.
- Sits between the pipeline MEM stage and a line-granular backing memory.
- Keeps the existing CPU-side handshake (is_input_valid / is_ready / is_output_valid / is_hit).
- New capabilities:
  - configurable associativity;
  - registered one-cycle hit latency;
  - ready/valid memory request channel with backpressure;
  - whole-cache flush command.

---
 rtl/cache_set_assoc.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_cache_set_assoc.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_set_assoc.sv
// N-way set-associative write-back, write-allocate data cache.
// It sits between the MEM stage and a line-granular backing memory.
// Replacement is true LRU, and misses are handled by an explicit state machine.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | ready; accept a CPU request (priority) or a flush command
// LOOKUP      | tag compare; a hit responds here, a miss latches the victim
// WRITEBACK   | write the dirty victim line to memory
// FILL_REQ    | issue the line read for the requested address
// FILL_WAIT   | wait for fill data, install it into the victim way
// RESPOND     | miss completion pulse
// FLUSH_SCAN  | visit one (set, way) per cycle, set-major order
// FLUSH_WB    | write back the dirty entry found by the scan
// FLUSH_DONE  | flush completion pulse
module cache_set_assoc #(
   parameter  int LINE_SIZE = 16,
   parameter  int NUM_SETS  = 16,
   parameter  int NUM_WAYS  = 2,
   localparam int OFF       = $clog2(LINE_SIZE),
   localparam int IDX       = $clog2(NUM_SETS),
   localparam int TAG       = 32 - IDX - OFF,
   localparam int LW        = 8 * LINE_SIZE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              is_input_valid,
   input  logic [31:0]       addr,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       din,
   input  logic              flush,
   output logic              is_ready,
   output logic              is_output_valid,
   output logic [31:0]       dout,
   output logic              is_hit,
   output logic              flush_done,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_write,
   output logic [32-OFF-1:0] mem_req_addr,
   output logic [LW-1:0]     mem_req_wdata,
   input  logic              mem_resp_valid,
   input  logic [LW-1:0]     mem_resp_rdata
);

   // Way and word index widths are kept at least 1 bit so a direct-mapped
   // cache or a one-word line still elaborates; the unused bit stays 0.
   localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int WB = (OFF > 2) ? (OFF - 2) : 1;

   typedef enum logic [3:0] {
      IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT, RESPOND,
      FLUSH_SCAN, FLUSH_WB, FLUSH_DONE
   } state_t;

   state_t state_q, state_d;

   logic           valid_q [NUM_SETS][NUM_WAYS];
   logic           dirty_q [NUM_SETS][NUM_WAYS];
   logic [TAG-1:0] tag_q   [NUM_SETS][NUM_WAYS];
   logic [LW-1:0]  data_q  [NUM_SETS][NUM_WAYS];
   logic [WW-1:0]  age_q   [NUM_SETS][NUM_WAYS];

   logic [32-OFF-1:0] req_line_q;
   logic [WB-1:0]     req_word_q;
   logic [31:0]       req_din_q;
   logic              req_write_q;
   logic [WW-1:0]     victim_q;
   logic [IDX-1:0]    flush_set_q;
   logic [WW-1:0]     flush_way_q;

   logic [TAG-1:0] req_tag;
   logic [IDX-1:0] req_idx;
   logic           accept;
   logic           hit;
   logic [WW-1:0]  hit_way;
   logic [WW-1:0]  victim_way;
   logic           victim_found;
   logic [LW-1:0]  hit_line_rd, hit_line_wr, fill_line, resp_line;
   logic [31:0]    hit_word, resp_word;
   logic           flush_dirty, flush_last, flush_adv;
   logic           lru_en;
   logic [WW-1:0]  lru_way;

   logic              rdy_c, ov_c, hit_c, fd_c, mrv_c, mrw_c;
   logic [31:0]       dout_c;
   logic [32-OFF-1:0] mra_c;
   logic [LW-1:0]     mrd_c;

   assign req_tag = req_line_q[TAG+IDX-1:IDX];
   assign req_idx = req_line_q[IDX-1:0];
   assign accept  = (state_q == IDLE) && is_input_valid && (mem_read || mem_write);

   // Tag compare across all ways of the requested set
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int k = 0; k < NUM_WAYS; k++) begin
         if (valid_q[req_idx][k] && (tag_q[req_idx][k] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WW'(k);
         end
      end
   end

   // Victim: lowest invalid way, else the oldest (age NUM_WAYS-1)
   always_comb begin
      victim_way   = '0;
      victim_found = 1'b0;
      for (int k = 0; k < NUM_WAYS; k++) begin
         if (!victim_found && !valid_q[req_idx][k]) begin
            victim_way   = WW'(k);
            victim_found = 1'b1;
         end
      end
      if (!victim_found) begin
         for (int k = 0; k < NUM_WAYS; k++) begin
            if (age_q[req_idx][k] == WW'(NUM_WAYS - 1)) victim_way = WW'(k);
         end
      end
   end

   // Word extraction and store-merge for the hit line and the fill line
   always_comb begin
      hit_line_rd = data_q[req_idx][hit_way];
      hit_word    = hit_line_rd[{req_word_q, 5'b0} +: 32];
      hit_line_wr = hit_line_rd;
      hit_line_wr[{req_word_q, 5'b0} +: 32] = req_din_q;
      fill_line   = mem_resp_rdata;
      if (req_write_q) fill_line[{req_word_q, 5'b0} +: 32] = req_din_q;
      resp_line   = data_q[req_idx][victim_q];
      resp_word   = resp_line[{req_word_q, 5'b0} +: 32];
   end

   assign flush_dirty = valid_q[flush_set_q][flush_way_q] && dirty_q[flush_set_q][flush_way_q];
   assign flush_last  = (flush_set_q == IDX'(NUM_SETS - 1)) && (flush_way_q == WW'(NUM_WAYS - 1));
   assign flush_adv   = ((state_q == FLUSH_SCAN) && !flush_dirty) ||
                        ((state_q == FLUSH_WB) && mem_req_ready);
   assign lru_en      = ((state_q == LOOKUP) && hit) || ((state_q == FILL_WAIT) && mem_resp_valid);
   assign lru_way     = (state_q == LOOKUP) ? hit_way : victim_q;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and per-state outputs
   always_comb begin
      state_d = state_q;
      rdy_c   = 1'b0;
      ov_c    = 1'b0;
      hit_c   = 1'b0;
      fd_c    = 1'b0;
      dout_c  = '0;
      mrv_c   = 1'b0;
      mrw_c   = 1'b0;
      mra_c   = '0;
      mrd_c   = '0;
      case (state_q)
         IDLE: begin
            rdy_c = 1'b1;
            if (accept)     state_d = LOOKUP;
            else if (flush) state_d = FLUSH_SCAN;
         end
         LOOKUP: begin
            if (hit) begin
               ov_c  = 1'b1;
               hit_c = 1'b1;
               if (!req_write_q) dout_c = hit_word;
               state_d = IDLE;
            end else if (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) begin
               state_d = WRITEBACK;
            end else begin
               state_d = FILL_REQ;
            end
         end
         WRITEBACK: begin
            mrv_c = 1'b1;
            mrw_c = 1'b1;
            mra_c = {tag_q[req_idx][victim_q], req_idx};
            mrd_c = data_q[req_idx][victim_q];
            if (mem_req_ready) state_d = FILL_REQ;
         end
         FILL_REQ: begin
            mrv_c = 1'b1;
            mra_c = req_line_q;
            if (mem_req_ready) state_d = FILL_WAIT;
         end
         FILL_WAIT: begin
            if (mem_resp_valid) state_d = RESPOND;
         end
         RESPOND: begin
            ov_c = 1'b1;
            if (!req_write_q) dout_c = resp_word;
            state_d = IDLE;
         end
         FLUSH_SCAN: begin
            if (flush_dirty)     state_d = FLUSH_WB;
            else if (flush_last) state_d = FLUSH_DONE;
         end
         FLUSH_WB: begin
            mrv_c = 1'b1;
            mrw_c = 1'b1;
            mra_c = {tag_q[flush_set_q][flush_way_q], flush_set_q};
            mrd_c = data_q[flush_set_q][flush_way_q];
            if (mem_req_ready) state_d = flush_last ? FLUSH_DONE : FLUSH_SCAN;
         end
         FLUSH_DONE: begin
            fd_c    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are forced low while reset is asserted, whatever the state
   assign is_ready        = reset & rdy_c;
   assign is_output_valid = reset & ov_c;
   assign is_hit          = reset & hit_c;
   assign flush_done      = reset & fd_c;
   assign mem_req_valid   = reset & mrv_c;
   assign mem_req_write   = reset & mrw_c;
   assign dout            = reset ? dout_c : '0;
   assign mem_req_addr    = reset ? mra_c  : '0;
   assign mem_req_wdata   = reset ? mrd_c  : '0;

   // Request capture, line storage, LRU ages and flush scan pointer
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
               age_q[s][w]   <= WW'(w);
            end
         end
         flush_set_q <= '0;
         flush_way_q <= '0;
      end else begin
         if (accept) begin
            req_line_q  <= addr[31:OFF];
            req_word_q  <= WB'(addr[OFF-1:0] >> 2);
            req_din_q   <= din;
            req_write_q <= mem_write;
         end
         if ((state_q == IDLE) && !accept && flush) begin
            flush_set_q <= '0;
            flush_way_q <= '0;
         end
         if (state_q == LOOKUP) begin
            if (hit) begin
               if (req_write_q) begin
                  data_q[req_idx][hit_way]  <= hit_line_wr;
                  dirty_q[req_idx][hit_way] <= 1'b1;
               end
            end else begin
               victim_q <= victim_way;
            end
         end
         if ((state_q == FILL_WAIT) && mem_resp_valid) begin
            valid_q[req_idx][victim_q] <= 1'b1;
            dirty_q[req_idx][victim_q] <= req_write_q;
            tag_q[req_idx][victim_q]   <= req_tag;
            data_q[req_idx][victim_q]  <= fill_line;
         end
         if (lru_en) begin
            for (int k = 0; k < NUM_WAYS; k++) begin
               if (age_q[req_idx][k] < age_q[req_idx][lru_way])
                  age_q[req_idx][k] <= age_q[req_idx][k] + 1'b1;
            end
            age_q[req_idx][lru_way] <= '0;
         end
         if ((state_q == FLUSH_WB) && mem_req_ready)
            dirty_q[flush_set_q][flush_way_q] <= 1'b0;
         if (flush_adv) begin
            if (flush_way_q == WW'(NUM_WAYS - 1)) begin
               flush_way_q <= '0;
               flush_set_q <= flush_set_q + 1'b1;
            end else begin
               flush_way_q <= flush_way_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cache_set_assoc.sv
// Directed bench for cache_set_assoc with default parameters (16 B lines,
// 16 sets, 2 ways). Inputs are driven and outputs sampled on the falling edge.
module tb_cache_set_assoc;

   logic         clk = 1'b0;
   logic         reset;
   logic         is_input_valid;
   logic [31:0]  addr;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  din;
   logic         flush;
   logic         is_ready;
   logic         is_output_valid;
   logic [31:0]  dout;
   logic         is_hit;
   logic         flush_done;
   logic         mem_req_valid;
   logic         mem_req_ready;
   logic         mem_req_write;
   logic [27:0]  mem_req_addr;
   logic [127:0] mem_req_wdata;
   logic         mem_resp_valid;
   logic [127:0] mem_resp_rdata;

   int tests  = 0;
   int errors = 0;

   // results of the most recent access() call
   logic [31:0] r_dout;
   logic        r_hit;
   int          r_lat;
   int          nev;
   logic        ev_w [8];
   logic [31:0] ev_a [8];
   logic [31:0] ev_d [8];

   cache_set_assoc dut (
      .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
      .mem_read(mem_read), .mem_write(mem_write), .din(din), .flush(flush),
      .is_ready(is_ready), .is_output_valid(is_output_valid), .dout(dout),
      .is_hit(is_hit), .flush_done(flush_done), .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] la, input int w);
      return 32'h1111_2221 + 32'(w) + ((la - 32'h10) << 8);
   endfunction

   function automatic logic [127:0] mk_line(input logic [31:0] la);
      logic [127:0] l;
      for (int w = 0; w < 4; w++) l[32*w +: 32] = mem_word(la, w);
      return l;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Issue one request and service memory traffic until it completes.
   task automatic access(input logic [31:0] a, input logic wr, input logic [31:0] d);
      bit          done = 0;
      int          resp_t = -1;
      logic [31:0] fill_la = '0;
      nev = 0;
      r_lat = 0;
      is_input_valid = 1'b1; addr = a; mem_read = !wr; mem_write = wr; din = d;
      @(negedge clk);
      is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         mem_req_ready  = 1'b0;
         mem_resp_valid = 1'b0;
         if (is_output_valid) begin
            done = 1; r_dout = dout; r_hit = is_hit; r_lat = c + 1;
         end else begin
            if (mem_req_valid && nev < 8) begin
               ev_w[nev] = mem_req_write;
               ev_a[nev] = 32'(mem_req_addr);
               ev_d[nev] = mem_req_wdata[31:0];
               nev++;
               mem_req_ready = 1'b1;
               if (!mem_req_write) begin resp_t = 2; fill_la = 32'(mem_req_addr); end
            end else if (resp_t == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_rdata = mk_line(fill_la);
               resp_t = -1;
            end else if (resp_t > 0) begin
               resp_t--;
            end
            @(negedge clk);
         end
      end
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      tests++;
      if (!done) begin
         errors++;
         $display("FAIL access_timeout addr=%h: no is_output_valid within 100 cycles", a);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if ({is_ready, is_output_valid, is_hit, flush_done, mem_req_valid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b exp 00000", {is_ready, is_output_valid, is_hit, flush_done, mem_req_valid});
      end
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if (is_ready !== 1'b1 || is_output_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: is_ready=%b ov=%b exp 1 0", is_ready, is_output_valid);
      end
   endtask

   task automatic test_cold_miss_hit();
      access(32'h104, 1'b0, 32'h0);
      tests++;
      if (nev !== 1 || ev_w[0] !== 1'b0 || ev_a[0] !== 32'h10) begin
         errors++;
         $display("FAIL cold_fill_req: nev=%0d w=%b a=%h exp 1 0 00000010", nev, ev_w[0], ev_a[0]);
      end
      tests++;
      if (r_hit !== 1'b0 || r_dout !== 32'h1111_2222) begin
         errors++;
         $display("FAIL cold_resp: hit=%b dout=%h exp 0 11112222", r_hit, r_dout);
      end
      access(32'h104, 1'b0, 32'h0);
      tests++;
      if (r_hit !== 1'b1 || r_lat !== 1 || nev !== 0 || r_dout !== 32'h1111_2222) begin
         errors++;
         $display("FAIL reload_hit: hit=%b lat=%0d nev=%0d dout=%h exp 1 1 0 11112222", r_hit, r_lat, nev, r_dout);
      end
   endtask

   task automatic test_store_hit();
      access(32'h104, 1'b1, 32'hDEAD_BEEF);
      tests++;
      if (r_hit !== 1'b1 || nev !== 0 || r_dout !== 32'h0 || r_lat !== 1) begin
         errors++;
         $display("FAIL store_hit: hit=%b nev=%0d dout=%h lat=%0d exp 1 0 0 1", r_hit, nev, r_dout, r_lat);
      end
      access(32'h104, 1'b0, 32'h0);
      tests++;
      if (r_hit !== 1'b1 || nev !== 0 || r_dout !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL load_after_store: hit=%b nev=%0d dout=%h exp 1 0 deadbeef", r_hit, nev, r_dout);
      end
      access(32'h100, 1'b0, 32'h0);
      tests++;
      if (r_hit !== 1'b1 || r_dout !== mem_word(32'h10, 0)) begin
         errors++;
         $display("FAIL neighbour_word: hit=%b dout=%h exp 1 %h", r_hit, r_dout, mem_word(32'h10, 0));
      end
   endtask

   task automatic test_lru_evict();
      do_reset();
      access(32'h100, 1'b1, 32'hCAFE_0001);
      tests++;
      if (r_hit !== 1'b0 || nev !== 1 || ev_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL lru_store_miss: hit=%b nev=%0d w=%b exp 0 1 0", r_hit, nev, ev_w[0]);
      end
      access(32'h000, 1'b0, 32'h0);
      access(32'h000, 1'b0, 32'h0);
      tests++;
      if (r_hit !== 1'b1 || r_dout !== mem_word(32'h0, 0)) begin
         errors++;
         $display("FAIL lru_second_load: hit=%b dout=%h exp 1 %h", r_hit, r_dout, mem_word(32'h0, 0));
      end
      access(32'h200, 1'b0, 32'h0);
      tests++;
      if (nev !== 2 || ev_w[0] !== 1'b1 || ev_a[0] !== 32'h10 || ev_d[0] !== 32'hCAFE_0001 ||
          ev_w[1] !== 1'b0 || ev_a[1] !== 32'h20) begin
         errors++;
         $display("FAIL lru_evict_order: nev=%0d ev0=%b/%h/%h ev1=%b/%h exp 2 1/10/cafe0001 0/20",
                  nev, ev_w[0], ev_a[0], ev_d[0], ev_w[1], ev_a[1]);
      end
      tests++;
      if (r_hit !== 1'b0 || r_dout !== mem_word(32'h20, 0)) begin
         errors++;
         $display("FAIL lru_evict_resp: hit=%b dout=%h exp 0 %h", r_hit, r_dout, mem_word(32'h20, 0));
      end
      access(32'h000, 1'b0, 32'h0);
      tests++;
      if (r_hit !== 1'b1 || nev !== 0) begin
         errors++;
         $display("FAIL lru_survivor_hit: hit=%b nev=%0d exp 1 0", r_hit, nev);
      end
      // 0x200 is now the oldest and clean: refill without write-back
      access(32'h100, 1'b0, 32'h0);
      tests++;
      if (r_hit !== 1'b0 || nev !== 1 || ev_w[0] !== 1'b0 || ev_a[0] !== 32'h10) begin
         errors++;
         $display("FAIL lru_clean_victim: hit=%b nev=%0d w=%b a=%h exp 0 1 0 10", r_hit, nev, ev_w[0], ev_a[0]);
      end
   endtask

   task automatic run_flush(output int fd_cnt, output bit done);
      fd_cnt = 0; done = 0; nev = 0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         mem_req_ready = 1'b0;
         if (flush_done) begin fd_cnt++; done = 1; end
         if (mem_req_valid && nev < 8) begin
            ev_w[nev] = mem_req_write;
            ev_a[nev] = 32'(mem_req_addr);
            ev_d[nev] = mem_req_wdata[31:0];
            nev++;
            mem_req_ready = 1'b1;
         end
         @(negedge clk);
      end
      mem_req_ready = 1'b0;
   endtask

   task automatic test_flush();
      int fd_cnt;
      bit done;
      do_reset();
      access(32'h030, 1'b0, 32'h0);
      access(32'h130, 1'b1, 32'h1313_0013);
      access(32'h090, 1'b1, 32'h0909_0009);
      run_flush(fd_cnt, done);
      tests++;
      if (!done || fd_cnt !== 1 || nev !== 2) begin
         errors++;
         $display("FAIL flush_count: done=%b fd=%0d nev=%0d exp 1 1 2", done, fd_cnt, nev);
      end
      tests++;
      if (ev_w[0] !== 1'b1 || ev_a[0] !== 32'h13 || ev_d[0] !== 32'h1313_0013 ||
          ev_w[1] !== 1'b1 || ev_a[1] !== 32'h09 || ev_d[1] !== 32'h0909_0009) begin
         errors++;
         $display("FAIL flush_order: ev0=%b/%h/%h ev1=%b/%h/%h exp 1/13/13130013 1/09/09090009",
                  ev_w[0], ev_a[0], ev_d[0], ev_w[1], ev_a[1], ev_d[1]);
      end
      tests++;
      if (flush_done !== 1'b0 || is_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_after: flush_done=%b is_ready=%b exp 0 1", flush_done, is_ready);
      end
      access(32'h130, 1'b0, 32'h0);
      tests++;
      if (r_hit !== 1'b1 || nev !== 0 || r_dout !== 32'h1313_0013) begin
         errors++;
         $display("FAIL flush_reload_s3: hit=%b nev=%0d dout=%h exp 1 0 13130013", r_hit, nev, r_dout);
      end
      access(32'h090, 1'b0, 32'h0);
      tests++;
      if (r_hit !== 1'b1 || nev !== 0 || r_dout !== 32'h0909_0009) begin
         errors++;
         $display("FAIL flush_reload_s9: hit=%b nev=%0d dout=%h exp 1 0 09090009", r_hit, nev, r_dout);
      end
      run_flush(fd_cnt, done);
      tests++;
      if (!done || fd_cnt !== 1 || nev !== 0) begin
         errors++;
         $display("FAIL flush_clean: done=%b fd=%0d nev=%0d exp 1 1 0", done, fd_cnt, nev);
      end
   endtask

   task automatic test_priority();
      is_input_valid = 1'b1; addr = 32'h130; mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      is_input_valid = 1'b0;
      tests++;
      if (is_ready !== 1'b1 || is_output_valid !== 1'b0) begin
         errors++;
         $display("FAIL no_op_ignored: is_ready=%b ov=%b exp 1 0", is_ready, is_output_valid);
      end
      is_input_valid = 1'b1; addr = 32'h130; mem_read = 1'b1; mem_write = 1'b1;
      din = 32'h0000_0077; flush = 1'b1;
      @(negedge clk);
      is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
      tests++;
      if (is_output_valid !== 1'b1 || is_hit !== 1'b1 || dout !== 32'h0) begin
         errors++;
         $display("FAIL req_over_flush: ov=%b hit=%b dout=%h exp 1 1 0", is_output_valid, is_hit, dout);
      end
      @(negedge clk);
      tests++;
      if (is_ready !== 1'b1 || flush_done !== 1'b0 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_dropped: is_ready=%b fd=%b mrv=%b exp 1 0 0", is_ready, flush_done, mem_req_valid);
      end
      access(32'h130, 1'b0, 32'h0);
      tests++;
      if (r_hit !== 1'b1 || r_dout !== 32'h0000_0077) begin
         errors++;
         $display("FAIL write_wins: hit=%b dout=%h exp 1 00000077", r_hit, r_dout);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      is_input_valid = 1'b1; addr = 32'h3C4; mem_read = 1'b1; mem_write = 1'b0;
      @(negedge clk);
      is_input_valid = 1'b0; mem_read = 1'b0;
      for (int c = 0; c < 10 && !mem_req_valid; c++) @(negedge clk);
      tests++;
      if (mem_req_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_req_timeout: mem_req_valid=%b exp 1", mem_req_valid);
      end
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== 28'h3C || mem_req_write !== 1'b0 || is_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall%0d: v=%b a=%h w=%b rdy=%b exp 1 3c 0 0",
                     i, mem_req_valid, mem_req_addr, mem_req_write, is_ready);
         end
         @(negedge clk);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      tests++;
      if (mem_req_valid !== 1'b0 || is_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_accepted: v=%b rdy=%b exp 0 0", mem_req_valid, is_ready);
      end
      @(negedge clk);
      mem_resp_valid = 1'b1; mem_resp_rdata = mk_line(32'h3C);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      tests++;
      if (is_output_valid !== 1'b1 || is_hit !== 1'b0 || dout !== mem_word(32'h3C, 1)) begin
         errors++;
         $display("FAIL bp_resp: ov=%b hit=%b dout=%h exp 1 0 %h", is_output_valid, is_hit, dout, mem_word(32'h3C, 1));
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_miss();
      is_input_valid = 1'b1; addr = 32'h5A8; mem_read = 1'b1; mem_write = 1'b0;
      @(negedge clk);
      is_input_valid = 1'b0; mem_read = 1'b0;
      for (int c = 0; c < 10 && !mem_req_valid; c++) @(negedge clk);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      tests++;
      if (mem_req_valid !== 1'b0 || is_ready !== 1'b0) begin
         errors++;
         $display("FAIL rmm_fill_wait: v=%b rdy=%b exp 0 0", mem_req_valid, is_ready);
      end
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (is_ready !== 1'b0 || is_output_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL rmm_during_reset: rdy=%b ov=%b v=%b exp 0 0 0", is_ready, is_output_valid, mem_req_valid);
      end
      reset = 1'b1;
      mem_resp_valid = 1'b1; mem_resp_rdata = mk_line(32'h5A);
      #1;
      tests++;
      if (is_ready !== 1'b1) begin
         errors++;
         $display("FAIL rmm_release: is_ready=%b exp 1", is_ready);
      end
      @(negedge clk);
      mem_resp_valid = 1'b0;
      tests++;
      if (is_output_valid !== 1'b0 || is_ready !== 1'b1) begin
         errors++;
         $display("FAIL rmm_late_resp: ov=%b rdy=%b exp 0 1", is_output_valid, is_ready);
      end
      access(32'h5A8, 1'b0, 32'h0);
      tests++;
      if (r_hit !== 1'b0 || nev !== 1 || ev_a[0] !== 32'h5A || r_dout !== mem_word(32'h5A, 2)) begin
         errors++;
         $display("FAIL rmm_reload_miss: hit=%b nev=%0d a=%h dout=%h exp 0 1 5a %h",
                  r_hit, nev, ev_a[0], r_dout, mem_word(32'h5A, 2));
      end
   endtask

   initial begin
      reset = 1'b0; is_input_valid = 1'b0; addr = '0; mem_read = 1'b0; mem_write = 1'b0;
      din = '0; flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      test_reset();
      test_cold_miss_hit();
      test_store_hit();
      test_lru_evict();
      test_flush();
      test_priority();
      test_backpressure();
      test_reset_mid_miss();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
